// File: rtl/n64_ctrl_responder.sv
// Controller-side N64 single-wire responder: decodes the host command and replies
// with the button word (0x01) or identity word (0x00/0xFF) on the open-drain line.
module n64_ctrl_responder #(
  parameter int          BIT_CYCLES     = 400,
  parameter int          LOW1_CYCLES    = 100,
  parameter int          LOW0_CYCLES    = 300,
  parameter int          TURN_CYCLES    = 200,
  parameter int          TIMEOUT_CYCLES = 800,
  parameter logic [23:0] ID_WORD        = 24'h050002
) (
  input  logic        PCLK,
  input  logic        PRESET,
  inout  wire         inoutData,
  input  logic [31:0] buttons,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        busy,
  output logic        frame_err
);

  localparam int MAXC = (TIMEOUT_CYCLES > BIT_CYCLES) ? TIMEOUT_CYCLES : BIT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'(BIT_CYCLES / 2);
  localparam logic [CW-1:0] LOW1_LAST = CW'(LOW1_CYCLES - 1);
  localparam logic [CW-1:0] LOW0_LAST = CW'(LOW0_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RX_LOW, RX_HIGH, TURN, TX_LOW, TX_HIGH, TX_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     sync_q;
  logic           prev_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     cmd_sr_q, cmd_sr_d;
  logic [31:0]    tx_sr_q, tx_sr_d;
  logic [5:0]     tx_left_q, tx_left_d;
  logic           drive_q, drive_d;
  logic           busy_q, busy_d;
  logic           cmd_valid_q, cmd_valid_d;
  logic [7:0]     cmd_code_q, cmd_code_d;
  logic           frame_err_q, frame_err_d;

  logic rx_line, fall, rise, rx_bit;

  assign rx_line = sync_q[1];
  assign fall    = prev_q & ~rx_line;
  assign rise    = ~prev_q & rx_line;
  // Short low pulse means '1', long low pulse means '0'.
  assign rx_bit  = (cnt_q < HALF_BIT);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      cmd_sr_q    <= '0;
      tx_sr_q     <= '0;
      tx_left_q   <= '0;
      drive_q     <= 1'b0;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], inoutData};
      prev_q      <= rx_line;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      tx_sr_q     <= tx_sr_d;
      tx_left_q   <= tx_left_d;
      drive_q     <= drive_d;
      busy_q      <= busy_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_sr_d    = cmd_sr_q;
    tx_sr_d     = tx_sr_q;
    tx_left_d   = tx_left_q;
    drive_d     = drive_q;
    busy_d      = busy_q;
    cmd_code_d  = cmd_code_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = RX_LOW;
          cnt_d     = '0;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end

      RX_LOW: begin
        if (rise) begin
          cnt_d = '0;
          if (bit_cnt_q == 4'd8) begin
            if (!rx_bit) begin
              frame_err_d = 1'b1;
              busy_d      = 1'b0;
              state_d     = IDLE;
            end else begin
              cmd_valid_d = 1'b1;
              cmd_code_d  = cmd_sr_q;
              if (cmd_sr_q == 8'h01) begin
                tx_sr_d   = buttons;
                tx_left_d = 6'd32;
                state_d   = TURN;
              end else if (cmd_sr_q == 8'h00 || cmd_sr_q == 8'hFF) begin
                tx_sr_d   = {ID_WORD, 8'h00};
                tx_left_d = 6'd24;
                state_d   = TURN;
              end else begin
                busy_d  = 1'b0;
                state_d = IDLE;
              end
            end
          end else begin
            cmd_sr_d  = {cmd_sr_q[6:0], rx_bit};
            bit_cnt_d = bit_cnt_q + 4'd1;
            state_d   = RX_HIGH;
          end
        end else if (cnt_q == TO_LAST) begin
          // Line stuck low: abort; IDLE only re-arms on a fresh falling edge.
          frame_err_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RX_HIGH: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = RX_LOW;
        end else if (cnt_q == TO_LAST) begin
          frame_err_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          drive_d = 1'b1;
          state_d = TX_LOW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      TX_LOW: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == (tx_sr_q[31] ? LOW1_LAST : LOW0_LAST)) begin
          drive_d = 1'b0;
          state_d = TX_HIGH;
        end
      end

      TX_HIGH: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          drive_d = 1'b1;
          if (tx_left_q == 6'd1) begin
            state_d = TX_STOP;
          end else begin
            tx_sr_d   = {tx_sr_q[30:0], 1'b0};
            tx_left_d = tx_left_q - 6'd1;
            state_d   = TX_LOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      TX_STOP: begin
        if (cnt_q == LOW1_LAST) begin
          drive_d = 1'b0;
        end
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign inoutData = drive_q ? 1'b0 : 1'bz;
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_n64_ctrl_responder.sv
// Bench for n64_ctrl_responder: host-side bit-banging of command frames, reply decoding
// by sampling mid-cell, and a reference model of which reply each command must produce.
`timescale 1ns/1ps
module tb_n64_ctrl_responder;

  // Timing scaled down by 4 from the 100 MHz defaults to keep the run short.
  localparam int          BIT    = 100;
  localparam int          LOW1   = 25;
  localparam int          LOW0   = 75;
  localparam int          TURN   = 50;
  localparam int          TMO    = 200;
  localparam logic [23:0] ID     = 24'h050002;
  localparam int          SAMPLE = BIT / 2 + 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_drv = 1'b0;
  logic [31:0] buttons = 32'h0;
  wire         line;
  logic        cmd_valid, busy, frame_err;
  logic [7:0]  cmd_code;

  int checks = 0, errors = 0;
  int cyc = 0, rel_cyc = 0;
  int n_valid = 0, n_err = 0;
  logic [7:0] exp_code = 8'h00;
  bit code_chk = 1'b0;
  bit tx_window = 1'b0;

  assign line = host_drv ? 1'b0 : 1'bz;
  pullup (line);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  n64_ctrl_responder #(
    .BIT_CYCLES(BIT), .LOW1_CYCLES(LOW1), .LOW0_CYCLES(LOW0),
    .TURN_CYCLES(TURN), .TIMEOUT_CYCLES(TMO), .ID_WORD(ID)
  ) dut (
    .PCLK(clk), .PRESET(rst), .inoutData(line), .buttons(buttons),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .busy(busy), .frame_err(frame_err)
  );

  // Reference model: reply length and content depend only on the command code.
  function automatic int model_len(input logic [7:0] c);
    if (c == 8'h01) return 32;
    if (c == 8'h00 || c == 8'hFF) return 24;
    return 0;
  endfunction

  function automatic logic [31:0] model_word(input logic [7:0] c, input logic [31:0] btn);
    return (c == 8'h01) ? btn : {8'h00, ID};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulse counters and per-cycle compare against the model's tracked state.
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_err++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (code_chk) begin
        checks++;
        if (cmd_code !== exp_code) begin
          errors++;
          $display("FAIL cmd_code_track: got %h, expected %h (cycle %0d)", cmd_code, exp_code, cyc);
        end
      end
      if (!tx_window) begin
        checks++;
        if (line === 1'b0 && !host_drv) begin
          errors++;
          $display("FAIL spurious_drive: line low with no reply expected (cycle %0d), expected released", cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_bit(input bit b, input int jit, input bit last);
    int lo;
    lo = (b ? LOW1 : LOW0) + jit;
    host_drv = 1'b1;
    idle(lo);
    host_drv = 1'b0;
    if (!last) idle(BIT - lo);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input bit stop, input bit rnd);
    logic [8:0] bits;
    int j;
    bits = {cmd, stop};
    for (int i = 8; i >= 0; i--) begin
      j = rnd ? (int'($urandom_range(0, 16)) - 8) : 0;
      if (i == 0 && stop) code_chk = 1'b0;
      host_bit(bits[i], j, i == 0);
      if (i == 8) check("busy_in_frame", 32'(busy), 32'd1);
    end
    rel_cyc = cyc;
    if (stop) begin
      idle(5);
      exp_code = cmd;
      code_chk = 1'b1;
    end
  endtask

  task automatic wait_fall(input int bound, output bit ok);
    logic p;
    p  = line;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (p === 1'b1 && line === 1'b0) begin
        ok = 1'b1;
        break;
      end
      p = line;
    end
  endtask

  // Decodes nbits data bits plus stop; returns early at the falling edge of bit abort_at.
  task automatic rx_reply(input int nbits, input logic [31:0] exp_word, input int abort_at,
                          input bit scramble);
    bit ok, done;
    int lat;
    logic b;
    logic [31:0] word;
    word = 32'h0;
    wait_fall(TURN + 10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reply_start: no reply edge within %0d cycles, expected one", TURN + 10);
      tx_window = 1'b0;
      return;
    end
    lat = cyc - rel_cyc;
    checks++;
    if (lat < TURN + 2 || lat > TURN + 4) begin
      errors++;
      $display("FAIL reply_latency: got %0d cycles, expected %0d..%0d", lat, TURN + 2, TURN + 4);
    end
    for (int i = 0; i <= nbits; i++) begin
      if (i > 0) begin
        wait_fall(BIT + 5, ok);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL reply_cell: no edge for bit %0d, expected one within %0d cycles", i, BIT + 5);
          tx_window = 1'b0;
          return;
        end
      end
      if (i == abort_at) return;
      repeat (SAMPLE) @(negedge clk);
      b = (line === 1'b0) ? 1'b0 : 1'b1;
      if (i < nbits) word = {word[30:0], b};
      else begin
        check("stop_bit", 32'(b), 32'd1);
        check("busy_at_stop", 32'(busy), 32'd1);
      end
      if (scramble && i == 2) buttons = $urandom;
    end
    check("reply_word", word, exp_word);
    done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    check("busy_clear", 32'(done), 32'd1);
    tx_window = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, e0, n;
    logic [7:0]  c;
    logic [31:0] snap;

    // Reset state
    idle(5);
    check("rst_line", 32'(line), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_code", 32'(cmd_code), 32'h00);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    exp_code = 8'h00;
    code_chk = 1'b1;
    idle(20);

    // Poll 0x01 with a fixed button word
    buttons = 32'h8001_A55A;
    v0 = n_valid;
    tx_window = 1'b1;
    send_frame(8'h01, 1'b1, 1'b0);
    rx_reply(32, 32'h8001_A55A, -1, 1'b0);
    check("poll_valid_pulse", 32'(n_valid - v0), 32'd1);
    check("poll_cmd_code", 32'(cmd_code), 32'h01);
    idle(50);

    // Identity queries 0x00 then 0xFF
    tx_window = 1'b1;
    send_frame(8'h00, 1'b1, 1'b0);
    rx_reply(24, 32'h0005_0002, -1, 1'b0);
    idle(50);
    tx_window = 1'b1;
    send_frame(8'hFF, 1'b1, 1'b0);
    rx_reply(24, 32'h0005_0002, -1, 1'b0);
    check("id_ff_cmd_code", 32'(cmd_code), 32'hFF);
    idle(50);

    // Unknown command: pulse only, line stays released
    v0 = n_valid; e0 = n_err;
    send_frame(8'h42, 1'b1, 1'b0);
    idle(500);
    check("unk_valid_pulse", 32'(n_valid - v0), 32'd1);
    check("unk_cmd_code", 32'(cmd_code), 32'h42);
    check("unk_no_err", 32'(n_err - e0), 32'd0);
    check("unk_busy", 32'(busy), 32'd0);

    // Stop bit sent as '0'
    v0 = n_valid; e0 = n_err;
    send_frame(8'h01, 1'b0, 1'b0);
    idle(300);
    check("stop0_err_pulse", 32'(n_err - e0), 32'd1);
    check("stop0_no_valid", 32'(n_valid - v0), 32'd0);
    check("stop0_busy", 32'(busy), 32'd0);
    idle(50);

    // Line held low mid-command, then a normal poll
    e0 = n_err;
    host_bit(1'b0, 0, 1'b0);
    host_bit(1'b0, 0, 1'b0);
    host_drv = 1'b1;
    idle(TMO + 25);
    host_drv = 1'b0;
    idle(20);
    check("timeout_err_pulse", 32'(n_err - e0), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    idle(50);
    buttons = 32'h1234_5678;
    tx_window = 1'b1;
    send_frame(8'h01, 1'b1, 1'b0);
    rx_reply(32, 32'h1234_5678, -1, 1'b0);
    idle(50);

    // Reset pulsed while reply bit 10 is being driven
    buttons = 32'hDEAD_BEEF;
    tx_window = 1'b1;
    send_frame(8'h01, 1'b1, 1'b0);
    rx_reply(32, 32'hDEAD_BEEF, 10, 1'b0);
    rst = 1'b1;
    exp_code = 8'h00;
    #1;
    check("prst_line", 32'(line), 32'd1);
    check("prst_busy", 32'(busy), 32'd0);
    check("prst_cmd_code", 32'(cmd_code), 32'h00);
    check("prst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("prst_frame_err", 32'(frame_err), 32'd0);
    tx_window = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(30);
    tx_window = 1'b1;
    send_frame(8'h01, 1'b1, 1'b0);
    rx_reply(32, 32'hDEAD_BEEF, -1, 1'b0);
    idle(50);

    // Randomized frames against the model, with button changes during the reply
    for (int t = 0; t < 6; t++) begin
      case ($urandom_range(0, 3))
        0: c = 8'h01;
        1: c = 8'h00;
        2: c = 8'hFF;
        default: begin
          c = 8'($urandom);
          while (model_len(c) != 0) c = 8'($urandom);
        end
      endcase
      buttons = $urandom;
      snap = buttons;
      n = model_len(c);
      v0 = n_valid; e0 = n_err;
      tx_window = (n != 0);
      send_frame(c, 1'b1, 1'b1);
      if (n != 0) rx_reply(n, model_word(c, snap), -1, 1'b1);
      else idle(300);
      check("rand_valid_pulse", 32'(n_valid - v0), 32'd1);
      check("rand_no_err", 32'(n_err - e0), 32'd0);
      idle(50);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/n64_ctrl_responder.md
Name: n64_ctrl_responder

Overview:
- Controller-side end of the N64 single-wire protocol; emulates a standard pad so host-side polling logic can be exercised without a physical controller.
- Decodes the 8-bit command plus stop bit from the open-drain data line.
- Answers command 0x01 with the 32-bit button word and commands 0x00/0xFF with the 24-bit identity word; each reply ends with a stop bit.
- Sits beside the host block on the same fabric clock, driven by a test/stimulus register or external switches.

Parameters:
- BIT_CYCLES, 400, clocks per bit cell (4 us at 100 MHz).
- LOW1_CYCLES, 100, low time driven for a '1' and for the stop bit.
- LOW0_CYCLES, 300, low time driven for a '0'.
- TURN_CYCLES, 200, idle-high gap between the end of the host stop bit and the first reply bit.
- TIMEOUT_CYCLES, 800, maximum low or high time inside an incoming frame before it is aborted.
- ID_WORD, 24'h050002, identity reply for commands 0x00 and 0xFF.

Ports:
- PCLK  input  1  fabric clock.
- PRESET  input  1  reset, asynchronous, active-high.
- inoutData  inout  1  open-drain N64 data line; block drives 0 or releases to Z, never drives 1.
- buttons  input  32  live button word, MSB transmitted first.
- cmd_valid  output  1  one-cycle pulse when a complete command plus stop bit has been decoded.
- cmd_code  output  8  last decoded command, valid from the cmd_valid cycle until the next one.
- busy  output  1  high from the first falling edge of a frame until the reply stop bit is released.
- frame_err  output  1  one-cycle pulse on an aborted or malformed frame.

Behaviour:
- Reset (async assert, sync release): release line, all outputs 0, cmd_code 8'h00, FSM IDLE, counters 0.
- Input synchronizer: inoutData passes through 2 flops. All edge detection uses the synchronized copy, so there is 2 cycles of input latency. Falling edge = prev 1, cur 0.
- States: IDLE, RX_LOW, RX_HIGH, TURN, TX_LOW, TX_HIGH, TX_STOP.
- IDLE:
  - Falling edge -> RX_LOW; bit counter = 0; low counter = 0; busy = 1.
  - The block's own driven edges are ignored while in the TX states.
- RX_LOW:
  - Count cycles while the line is low.
  - On rising edge: bit = (low count < BIT_CYCLES/2) ? 1 : 0. Shift bit into the MSB-first command register, then -> RX_HIGH.
  - Low count reaching TIMEOUT_CYCLES -> frame_err pulse, wait for line high, -> IDLE.
- RX_HIGH:
  - Falling edge with bit counter < 8 -> RX_LOW.
  - The 9th received bit is the stop bit and must decode as '1'. A '0' gives frame_err and -> IDLE with no reply.
  - High time reaching TIMEOUT_CYCLES before 9 bits -> frame_err, -> IDLE.
- After a valid stop bit:
  - cmd_code <= command and cmd_valid pulses on the rising-edge cycle of the stop bit.
  - For 0x01: latch buttons into the shift register that same cycle, length 32.
  - For 0x00/0xFF: latch ID_WORD, length 24.
  - Then -> TURN.
  - Any other code: cmd_valid still pulses, no reply, busy drops, -> IDLE.
- TURN: hold line released for TURN_CYCLES, then -> TX_LOW.
- TX_LOW / TX_HIGH (per bit cell of BIT_CYCLES):
  - Drive low for LOW1_CYCLES (bit 1) or LOW0_CYCLES (bit 0), release for the remainder of the cell.
  - Bits go out MSB first.
  - After the last data bit -> TX_STOP.
- TX_STOP: low LOW1_CYCLES, release, wait out the rest of the cell, busy <= 0, -> IDLE.
- Timing: first falling edge of the reply occurs exactly TURN_CYCLES + 2 after the synchronized stop-bit rising edge (±1 cycle).
- buttons changes during TX do not affect the reply in flight.
- Counter widths: sized to hold max(TIMEOUT_CYCLES, BIT_CYCLES); no wrap within a frame.
- PRESET asserted mid-TX releases the line within the same clock edge (async), with no further drive.

Test Plan:
- Host-timed 0x01 + stop (0 = 300 low/100 high, 1 = 100 low/300 high), buttons = 32'h8001_A55A -> cmd_valid with cmd_code 8'h01; line carries 32 bits 8001A55A MSB first plus stop; a sample at 205 cycles after each falling edge reconstructs the word; busy clears after the stop cell.
- Command 0x00 -> 24-bit reply 050002 plus stop; repeat with 0xFF -> identical reply.
- Command 0x42 -> cmd_valid with cmd_code 8'h42; line stays released for 2000 cycles; frame_err stays 0.
- Stop bit sent as '0' after 0x01 -> frame_err pulse, no reply, busy returns to 0.
- Line held low 900 cycles mid-command -> frame_err pulse; a following valid 0x01 frame is answered normally.
- PRESET pulsed at reply bit 10 -> line released immediately, outputs zero; the next poll frame is answered correctly.
